// File: rtl/cpu_pkg.sv
// Shared types for the CPU bus arbiter: FSM state, transaction owner and the
// request-field bundle carried from a capture register to the memory port.
package cpu_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_e;

    localparam int unsigned TIMER_W = 16;

    typedef struct packed {
        logic [31:0] addr;
        logic        write;
        logic [3:0]  byte_enable;
        logic [31:0] wdata;
    } bus_req_t;

    function automatic owner_e other_side(input owner_e side);
        return (side == OWN_I) ? OWN_D : OWN_I;
    endfunction

endpackage

// File: rtl/cpu_busarb_capture.sv
// One-deep request capture register for one CPU side. Holds a pending flag and
// the request fields until the arbiter signals completion via clear.
module cpu_busarb_capture
    import cpu_pkg::*;
(
    input  logic     clock,
    input  logic     reset,
    input  logic     request,
    input  bus_req_t req_in,
    input  logic     clear,
    output logic     eligible,
    output bus_req_t fields
);

    logic     pending_d, pending_q;
    bus_req_t fields_d, fields_q;

    always_comb begin
        // NOTE: every signal gets its hold value first so no path leaves it
        // unassigned; otherwise synthesis infers a latch.
        pending_d = pending_q;
        fields_d  = fields_q;
        if (clear) begin
            pending_d = 1'b0;
        end
        // A new request is taken only if the slot is free or being freed now.
        if (request && (!pending_q || clear)) begin
            pending_d = 1'b1;
            fields_d  = req_in;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values
        // regardless of statement order.
        if (reset) begin
            pending_q <= 1'b0;
            fields_q  <= '0;
        end else begin
            pending_q <= pending_d;
            fields_q  <= fields_d;
        end
    end

    assign eligible = pending_q || request;
    assign fields   = pending_q ? fields_q : req_in;

endmodule

// File: rtl/cpu_bus_arbiter.sv
// Arbitrates instruction-fetch and data requests onto one shared memory port
// with round-robin priority, back-to-back re-grant and a completion timeout.
module cpu_bus_arbiter
    import cpu_pkg::*;
#(
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cpui_request,
    input  logic [31:0] cpui_addr,
    output logic [31:0] cpui_rdata,
    output logic        cpui_ack,
    input  logic        cpud_request,
    input  logic [31:0] cpud_addr,
    input  logic        cpud_write,
    input  logic [3:0]  cpud_byte_enable,
    input  logic [31:0] cpud_wdata,
    output logic [31:0] cpud_rdata,
    output logic        cpud_ack,
    output logic        mem_request,
    output logic [31:0] mem_addr,
    output logic        mem_write,
    output logic [3:0]  mem_byte_enable,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        timeout_error
);

    localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMER_W'(TIMEOUT - 1);

    arb_state_e         state_d, state_q;
    owner_e             owner_d, owner_q;
    owner_e             last_grant_d, last_grant_q;
    logic [TIMER_W-1:0] count_d, count_q;
    logic               mem_request_d, mem_request_q;
    bus_req_t           bus_d, bus_q;

    bus_req_t i_req_in, d_req_in, i_fields, d_fields;
    logic     i_eligible, d_eligible;
    logic     done, timed_out, grant;
    owner_e   grant_side;

    // Fetches are always full-word reads.
    assign i_req_in = '{addr: cpui_addr, write: 1'b0, byte_enable: 4'hF, wdata: 32'h0};
    assign d_req_in = '{addr: cpud_addr, write: cpud_write,
                        byte_enable: cpud_byte_enable, wdata: cpud_wdata};

    cpu_busarb_capture u_cap_i (
        .clock    (clock),
        .reset    (reset),
        .request  (cpui_request),
        .req_in   (i_req_in),
        .clear    (cpui_ack),
        .eligible (i_eligible),
        .fields   (i_fields)
    );

    cpu_busarb_capture u_cap_d (
        .clock    (clock),
        .reset    (reset),
        .request  (cpud_request),
        .req_in   (d_req_in),
        .clear    (cpud_ack),
        .eligible (d_eligible),
        .fields   (d_fields)
    );

    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        last_grant_d  = last_grant_q;
        count_d       = count_q;
        mem_request_d = 1'b0;
        bus_d         = bus_q;
        done          = 1'b0;
        timed_out     = 1'b0;
        grant         = 1'b0;
        grant_side    = OWN_I;

        case (state_q)
            IDLE: begin
                if (i_eligible || d_eligible) begin
                    grant = 1'b1;
                    if (i_eligible && d_eligible) begin
                        grant_side = other_side(last_grant_q);
                    end else begin
                        grant_side = d_eligible ? OWN_D : OWN_I;
                    end
                end
            end
            BUSY: begin
                // A real ack always beats a coincident timeout.
                if (mem_ack) begin
                    done = 1'b1;
                end else if (count_q == TIMEOUT_LAST) begin
                    done      = 1'b1;
                    timed_out = 1'b1;
                end else begin
                    count_d = count_q + 16'd1;
                end
                if (done) begin
                    grant_side = other_side(owner_q);
                    grant      = (owner_q == OWN_I) ? d_eligible : i_eligible;
                    if (!grant) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (grant) begin
            state_d       = BUSY;
            owner_d       = grant_side;
            last_grant_d  = grant_side;
            count_d       = '0;
            mem_request_d = 1'b1;
            bus_d         = (grant_side == OWN_D) ? d_fields : i_fields;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            owner_q       <= OWN_I;
            last_grant_q  <= OWN_I;
            count_q       <= '0;
            mem_request_q <= 1'b0;
            bus_q         <= '0;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            last_grant_q  <= last_grant_d;
            count_q       <= count_d;
            mem_request_q <= mem_request_d;
            bus_q         <= bus_d;
        end
    end

    assign mem_request     = mem_request_q;
    assign mem_addr        = bus_q.addr;
    assign mem_write       = bus_q.write;
    assign mem_byte_enable = bus_q.byte_enable;
    assign mem_wdata       = bus_q.wdata;

    assign cpui_ack      = done && (owner_q == OWN_I);
    assign cpud_ack      = done && (owner_q == OWN_D);
    assign timeout_error = timed_out;

    // Read data is a pass-through, zeroed only for a timed-out owner or in reset.
    assign cpui_rdata = (reset || (timed_out && owner_q == OWN_I)) ? 32'h0 : mem_rdata;
    assign cpud_rdata = (reset || (timed_out && owner_q == OWN_D)) ? 32'h0 : mem_rdata;

endmodule

// File: tb/tb_cpu_bus_arbiter.sv
// Directed self-checking bench for cpu_bus_arbiter with TIMEOUT=8.
module tb_cpu_bus_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        cpui_request;
    logic [31:0] cpui_addr;
    logic [31:0] cpui_rdata;
    logic        cpui_ack;
    logic        cpud_request;
    logic [31:0] cpud_addr;
    logic        cpud_write;
    logic [3:0]  cpud_byte_enable;
    logic [31:0] cpud_wdata;
    logic [31:0] cpud_rdata;
    logic        cpud_ack;
    logic        mem_request;
    logic [31:0] mem_addr;
    logic        mem_write;
    logic [3:0]  mem_byte_enable;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        timeout_error;

    int errors = 0;
    int checks = 0;

    cpu_bus_arbiter #(.TIMEOUT(8)) dut (
        .clock            (clock),
        .reset            (reset),
        .cpui_request     (cpui_request),
        .cpui_addr        (cpui_addr),
        .cpui_rdata       (cpui_rdata),
        .cpui_ack         (cpui_ack),
        .cpud_request     (cpud_request),
        .cpud_addr        (cpud_addr),
        .cpud_write       (cpud_write),
        .cpud_byte_enable (cpud_byte_enable),
        .cpud_wdata       (cpud_wdata),
        .cpud_rdata       (cpud_rdata),
        .cpud_ack         (cpud_ack),
        .mem_request      (mem_request),
        .mem_addr         (mem_addr),
        .mem_write        (mem_write),
        .mem_byte_enable  (mem_byte_enable),
        .mem_wdata        (mem_wdata),
        .mem_rdata        (mem_rdata),
        .mem_ack          (mem_ack),
        .timeout_error    (timeout_error)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed=%08h expected=%08h", tag, observed, expected);
        end
    endtask

    // Each cycle: inputs change 1 time unit after the rising edge, outputs are
    // sampled 2 units later, well before the next edge.
    task automatic next_cycle();
        @(posedge clock);
        #1;
        cpui_request = 1'b0;
        cpud_request = 1'b0;
        mem_ack      = 1'b0;
    endtask

    task automatic settle();
        #2;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset            = 1'b1;
        cpui_request     = 1'b0;
        cpui_addr        = 32'h0;
        cpud_request     = 1'b0;
        cpud_addr        = 32'h0;
        cpud_write       = 1'b0;
        cpud_byte_enable = 4'h0;
        cpud_wdata       = 32'h0;
        mem_rdata        = 32'hFFFF_FFFF;
        mem_ack          = 1'b0;

        // Reset state: everything zero, even with mem_rdata non-zero.
        repeat (2) @(posedge clock);
        #1;
        check("rst_mem_request", {31'b0, mem_request}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_be", {28'b0, mem_byte_enable}, 32'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        check("rst_cpui_ack", {31'b0, cpui_ack}, 32'd0);
        check("rst_cpud_ack", {31'b0, cpud_ack}, 32'd0);
        check("rst_cpui_rdata", cpui_rdata, 32'h0);
        check("rst_cpud_rdata", cpud_rdata, 32'h0);
        check("rst_timeout", {31'b0, timeout_error}, 32'd0);

        // Single fetch in the first cycle after reset release, ack 2 cycles later.
        next_cycle();
        reset = 1'b0;
        mem_rdata = 32'h0;
        cpui_request = 1'b1;
        cpui_addr = 32'h0000_0100;
        settle();
        check("f1_req_cycle_no_memreq", {31'b0, mem_request}, 32'd0);
        next_cycle();
        settle();
        check("f1_memreq", {31'b0, mem_request}, 32'd1);
        check("f1_addr", mem_addr, 32'h0000_0100);
        check("f1_write", {31'b0, mem_write}, 32'd0);
        check("f1_be", {28'b0, mem_byte_enable}, 32'hF);
        check("f1_wdata", mem_wdata, 32'h0);
        check("f1_no_early_ack", {31'b0, cpui_ack}, 32'd0);
        next_cycle();
        settle();
        check("f1_memreq_pulse", {31'b0, mem_request}, 32'd0);
        check("f1_addr_held", mem_addr, 32'h0000_0100);
        next_cycle();
        mem_ack = 1'b1;
        mem_rdata = 32'h1234_5678;
        settle();
        check("f1_cpui_ack", {31'b0, cpui_ack}, 32'd1);
        check("f1_cpui_rdata", cpui_rdata, 32'h1234_5678);
        check("f1_cpud_ack", {31'b0, cpud_ack}, 32'd0);
        check("f1_cpud_rdata_mirror", cpud_rdata, 32'h1234_5678);
        check("f1_no_timeout", {31'b0, timeout_error}, 32'd0);
        next_cycle();
        settle();
        check("f1_ack_pulse", {31'b0, cpui_ack}, 32'd0);
        check("f1_idle_no_memreq", {31'b0, mem_request}, 32'd0);

        // Simultaneous I and D right after reset: D wins, I follows back-to-back.
        next_cycle();
        reset = 1'b1;
        settle();
        next_cycle();
        reset = 1'b0;
        cpui_request = 1'b1;
        cpui_addr = 32'h0000_0200;
        cpud_request = 1'b1;
        cpud_addr = 32'h0000_8000;
        cpud_write = 1'b0;
        cpud_byte_enable = 4'hF;
        cpud_wdata = 32'h0;
        settle();
        next_cycle();
        settle();
        check("rr_first_memreq", {31'b0, mem_request}, 32'd1);
        check("rr_first_is_d", mem_addr, 32'h0000_8000);
        next_cycle();
        mem_ack = 1'b1;
        mem_rdata = 32'hAAAA_5555;
        settle();
        check("rr_cpud_ack", {31'b0, cpud_ack}, 32'd1);
        check("rr_cpud_rdata", cpud_rdata, 32'hAAAA_5555);
        check("rr_cpui_ack_quiet", {31'b0, cpui_ack}, 32'd0);
        next_cycle();
        settle();
        check("rr_second_memreq", {31'b0, mem_request}, 32'd1);
        check("rr_second_is_i", mem_addr, 32'h0000_0200);
        next_cycle();
        mem_ack = 1'b1;
        mem_rdata = 32'h0BAD_F00D;
        settle();
        check("rr_cpui_ack", {31'b0, cpui_ack}, 32'd1);
        check("rr_cpud_ack_quiet", {31'b0, cpud_ack}, 32'd0);
        next_cycle();
        settle();
        check("rr_idle", {31'b0, mem_request}, 32'd0);

        // D write arrives during a fetch; a second D request while pending is dropped.
        next_cycle();
        cpui_request = 1'b1;
        cpui_addr = 32'h0000_0300;
        settle();
        next_cycle();
        cpud_request = 1'b1;
        cpud_addr = 32'h0000_0040;
        cpud_write = 1'b1;
        cpud_byte_enable = 4'b0011;
        cpud_wdata = 32'hCAFE_BABE;
        settle();
        check("wr_fetch_memreq", mem_addr, 32'h0000_0300);
        next_cycle();
        mem_ack = 1'b1;
        mem_rdata = 32'h0000_0033;
        cpud_request = 1'b1;
        cpud_addr = 32'h0000_0999;
        cpud_write = 1'b0;
        cpud_byte_enable = 4'hC;
        cpud_wdata = 32'h0;
        settle();
        check("wr_fetch_ack", {31'b0, cpui_ack}, 32'd1);
        check("wr_fetch_addr_held", mem_addr, 32'h0000_0300);
        next_cycle();
        settle();
        check("wr_b2b_memreq", {31'b0, mem_request}, 32'd1);
        check("wr_addr", mem_addr, 32'h0000_0040);
        check("wr_write", {31'b0, mem_write}, 32'd1);
        check("wr_be", {28'b0, mem_byte_enable}, 32'h3);
        check("wr_wdata", mem_wdata, 32'hCAFE_BABE);
        next_cycle();
        settle();
        check("wr_memreq_pulse", {31'b0, mem_request}, 32'd0);
        check("wr_addr_held", mem_addr, 32'h0000_0040);
        check("wr_be_held", {28'b0, mem_byte_enable}, 32'h3);
        check("wr_wdata_held", mem_wdata, 32'hCAFE_BABE);
        next_cycle();
        mem_ack = 1'b1;
        mem_rdata = 32'h0000_0044;
        settle();
        check("wr_cpud_ack", {31'b0, cpud_ack}, 32'd1);
        check("wr_cpui_ack_quiet", {31'b0, cpui_ack}, 32'd0);
        next_cycle();
        settle();
        check("wr_dropped_req_no_memreq", {31'b0, mem_request}, 32'd0);

        // Timeout: D read, no ack; synthetic completion in the 8th BUSY cycle.
        next_cycle();
        cpud_request = 1'b1;
        cpud_addr = 32'h0000_0500;
        cpud_write = 1'b0;
        cpud_byte_enable = 4'hF;
        cpud_wdata = 32'h0;
        mem_rdata = 32'hDEAD_BEEF;
        settle();
        for (int b = 1; b <= 7; b++) begin
            next_cycle();
            settle();
            check($sformatf("to_busy%0d_no_ack", b), {31'b0, cpud_ack}, 32'd0);
            check($sformatf("to_busy%0d_no_err", b), {31'b0, timeout_error}, 32'd0);
        end
        next_cycle();
        settle();
        check("to_cpud_ack", {31'b0, cpud_ack}, 32'd1);
        check("to_cpud_rdata_zero", cpud_rdata, 32'h0);
        check("to_cpui_rdata_mirror", cpui_rdata, 32'hDEAD_BEEF);
        check("to_error", {31'b0, timeout_error}, 32'd1);
        check("to_cpui_ack_quiet", {31'b0, cpui_ack}, 32'd0);
        next_cycle();
        mem_ack = 1'b1;
        settle();
        check("to_idle_ack_ignored_d", {31'b0, cpud_ack}, 32'd0);
        check("to_idle_ack_ignored_i", {31'b0, cpui_ack}, 32'd0);
        check("to_error_pulse", {31'b0, timeout_error}, 32'd0);
        check("to_idle_no_memreq", {31'b0, mem_request}, 32'd0);
        next_cycle();
        settle();
        check("to_idle_stays", {31'b0, mem_request}, 32'd0);

        // Ack coincident with the timeout cycle: the real ack wins.
        next_cycle();
        cpud_request = 1'b1;
        cpud_addr = 32'h0000_0540;
        settle();
        repeat (7) next_cycle();
        next_cycle();
        mem_ack = 1'b1;
        mem_rdata = 32'h5A5A_5A5A;
        settle();
        check("tie_cpud_ack", {31'b0, cpud_ack}, 32'd1);
        check("tie_cpud_rdata", cpud_rdata, 32'h5A5A_5A5A);
        check("tie_no_error", {31'b0, timeout_error}, 32'd0);
        next_cycle();
        settle();
        check("tie_idle", {31'b0, mem_request}, 32'd0);

        // Reset in the 2nd BUSY cycle abandons the fetch; late ack is ignored.
        next_cycle();
        cpui_request = 1'b1;
        cpui_addr = 32'h0000_0600;
        settle();
        next_cycle();
        settle();
        check("ra_memreq", {31'b0, mem_request}, 32'd1);
        check("ra_addr", mem_addr, 32'h0000_0600);
        next_cycle();
        mem_rdata = 32'h0000_0077;
        reset = 1'b1;
        settle();
        check("ra_async_addr", mem_addr, 32'h0);
        check("ra_async_be", {28'b0, mem_byte_enable}, 32'h0);
        check("ra_async_rdata", cpui_rdata, 32'h0);
        next_cycle();
        reset = 1'b0;
        mem_ack = 1'b1;
        settle();
        check("ra_no_cpui_ack", {31'b0, cpui_ack}, 32'd0);
        check("ra_no_cpud_ack", {31'b0, cpud_ack}, 32'd0);
        check("ra_rdata_mirror", cpui_rdata, 32'h0000_0077);
        next_cycle();
        settle();
        check("ra_idle", {31'b0, mem_request}, 32'd0);
        next_cycle();
        cpui_request = 1'b1;
        cpui_addr = 32'h0000_0700;
        settle();
        next_cycle();
        settle();
        check("ra_clean_memreq", {31'b0, mem_request}, 32'd1);
        check("ra_clean_addr", mem_addr, 32'h0000_0700);
        next_cycle();
        mem_ack = 1'b1;
        mem_rdata = 32'h0000_7777;
        settle();
        check("ra_clean_ack", {31'b0, cpui_ack}, 32'd1);
        check("ra_clean_rdata", cpui_rdata, 32'h0000_7777);

        // Both sides re-request on every ack: grants alternate D,I,D,I...
        next_cycle();
        cpud_request = 1'b1;
        cpud_addr = 32'h0000_2000;
        cpud_write = 1'b0;
        cpud_byte_enable = 4'hF;
        cpui_request = 1'b1;
        cpui_addr = 32'h0000_1001;
        settle();
        for (int k = 0; k < 10; k++) begin
            next_cycle();
            settle();
            check($sformatf("alt%0d_memreq", k), {31'b0, mem_request}, 32'd1);
            check($sformatf("alt%0d_addr", k), mem_addr,
                  ((k % 2 == 0) ? 32'h0000_2000 : 32'h0000_1000) + 32'(k));
            next_cycle();
            mem_ack = 1'b1;
            mem_rdata = 32'(k);
            if (k < 8) begin
                if (k % 2 == 0) begin
                    cpud_request = 1'b1;
                    cpud_addr = 32'h0000_2000 + 32'(k + 2);
                end else begin
                    cpui_request = 1'b1;
                    cpui_addr = 32'h0000_1000 + 32'(k + 2);
                end
            end
            settle();
            check($sformatf("alt%0d_cpud_ack", k), {31'b0, cpud_ack}, (k % 2 == 0) ? 32'd1 : 32'd0);
            check($sformatf("alt%0d_cpui_ack", k), {31'b0, cpui_ack}, (k % 2 == 1) ? 32'd1 : 32'd0);
        end
        next_cycle();
        settle();
        check("alt_drained_idle", {31'b0, mem_request}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cpu_bus_arbiter.md
CPU_BUS_ARBITER -- requirements
Module: cpu_bus_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 1023: BUSY cycles without mem_ack before a synthetic completion is generated; legal range 2..65535.
REQ-002 clock  input  1  system clock, all state on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 cpui_request  input  1  instruction fetch request, one-cycle pulse.
REQ-005 cpui_addr  input  32  fetch address, valid in the request cycle.
REQ-006 cpui_rdata  output  32  fetch data, valid while cpui_ack=1.
REQ-007 cpui_ack  output  1  fetch complete, one-cycle pulse.
REQ-008 cpud_request  input  1  data request, one-cycle pulse.
REQ-009 cpud_addr / cpud_write / cpud_byte_enable / cpud_wdata  input  32/1/4/32  data request fields, valid in the request cycle.
REQ-010 cpud_rdata  output  32  read data, valid while cpud_ack=1.
REQ-011 cpud_ack  output  1  data transaction complete, one-cycle pulse.
REQ-012 mem_request  output  1  shared-port request, one-cycle pulse.
REQ-013 mem_addr / mem_write / mem_byte_enable / mem_wdata  output  32/1/4/32  shared-port fields, held stable from grant until completion.
REQ-014 mem_rdata  input  32  memory read data, valid with mem_ack.
REQ-015 mem_ack  input  1  memory completion pulse.
REQ-016 timeout_error  output  1  one-cycle pulse on synthetic completion.

Function
REQ-017 Each side has a capture register (pending flag + fields), loaded on its request pulse regardless of arbiter state.
REQ-018 A request arriving while the same side is already pending is dropped; the captured fields are unchanged.
REQ-019 FSM states: IDLE, BUSY; the owner register records I or D.
REQ-020 IDLE: the eligible set is (pending | request-this-cycle) per side. If non-empty, grant at the clock edge, enter BUSY, and drive mem_request=1 for exactly the first BUSY cycle.
REQ-021 Latency: a request in cycle N with the arbiter idle produces mem_request in cycle N+1.
REQ-022 Round-robin: if both sides are eligible, grant the side not recorded in last_grant; last_grant updates on every grant.
REQ-023 Fetch grant drives mem_write=0, mem_byte_enable=4'hF, mem_wdata=0. Data grant copies the captured cpud fields.
REQ-024 BUSY samples mem_ack from its first cycle (an ack coincident with mem_request is accepted). mem_ack in IDLE is ignored.
REQ-025 On mem_ack in BUSY, in the same cycle: owner's ack=1, owner's rdata=mem_rdata (combinational), owner's pending cleared. If the other side is eligible, re-grant directly (back-to-back, mem_request next cycle); otherwise go to IDLE.
REQ-026 The non-owner ack is always 0. Both rdata outputs mirror mem_rdata except during a timeout completion.
REQ-027 Timeout counter: 16-bit, cleared on grant, incremented each BUSY cycle without mem_ack.
REQ-028 When the counter reaches TIMEOUT-1 without ack: owner ack=1, owner rdata=0, timeout_error=1 in that cycle, pending cleared, then re-grant or IDLE as in REQ-025.
REQ-029 mem_ack and timeout in the same cycle: mem_ack wins; timeout_error=0.
REQ-030 An ack arriving late after a timeout is not filtered; memory shall never ack after TIMEOUT cycles.

Reset
REQ-031 Reset asserted: state=IDLE, both pending=0, last_grant=I, counter=0, all outputs 0, immediately (asynchronous).
REQ-032 Reset during BUSY abandons the transaction; no ack is ever issued for it.
REQ-033 Requests in the first cycle after reset deassertion are captured normally.

Structure
REQ-034 The shared package cpu_pkg holds the FSM state enum (IDLE, BUSY) and the owner enum (OWN_I, OWN_D).
REQ-035 Sub-module cpu_busarb_capture (request capture register plus pending flag) is instantiated twice, with the I-side write/wdata fields tied off.
REQ-036 Target size: 150-250 lines of RTL total.

Verification
REQ-037 Fetch 0x0000_0100; memory acks 2 cycles after mem_request with 0x1234_5678 -> mem_request in cycle N+1, cpui_ack and cpui_rdata=0x1234_5678 in the ack cycle, cpud_ack=0.
REQ-038 Simultaneous I (0x200) and D read (0x8000) right after reset -> D granted first, I mem_request in the cycle after the D ack.
REQ-039 D write addr 0x40, wdata 0xCAFE_BABE, be 4'b0011 while a fetch is BUSY -> D issued back-to-back after the fetch ack, with fields exact and held until ack.
REQ-040 TIMEOUT=8, no mem_ack -> cpud_ack=1, cpud_rdata=0, timeout_error=1 in the 8th BUSY cycle, then IDLE.
REQ-041 Reset asserted in the 2nd BUSY cycle, mem_ack one cycle later -> outputs 0 asynchronously, no cpui_ack/cpud_ack, clean fetch afterwards.
REQ-042 Both sides re-request on every ack for 10 transactions -> grants strictly alternate D,I,D,I...
